fp16_tree_arbiter: RTL
======================

Name: fp16_tree_arbiter

Overview:
- Shares one pipelined FP16 128-input adder tree between R requesters. The tree has a valid_in -> valid_out handshake and no stall.
- Round-robin arbitration; at most one vector is issued per cycle through a registered issue stage.
- Requester IDs are tracked in order in a tag FIFO, so the tree latency does not need to be known. Each tree result is steered back to the requester that issued it.
- Sits between the Mamba-2 SSM reduction consumers (y = C·h per head) and the single shared tree instance.

Parameters:
- DW, 16, FP16 element width
- N, 128, elements per vector (tree width)
- R, 4, number of requesters (2..8)
- TAG_DEPTH, 16, tag FIFO depth; must be >= tree latency + 1
- MAX_OUT, 4, max in-flight requests per requester

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  R  per-requester request
- req_ready  out  R  per-requester accept; combinational
- req_data  in  R*N*DW  requester r vector at bits [(r+1)*N*DW-1 -: N*DW]
- tree_valid_in  out  1  issue strobe to tree; registered
- tree_in_flat  out  N*DW  vector to tree; registered
- tree_valid_out  in  1  tree result strobe
- tree_sum  in  DW  tree result
- rsp_valid  out  R  one-hot result strobe; registered
- rsp_data  out  DW  result, shared by all requesters; registered
- busy  out  1  tag FIFO not empty or tree_valid_in high
- err_underflow  out  1  sticky; tree_valid_out seen with tag FIFO empty

Behaviour:
- Reset (async, rst=1):
  - tree_valid_in=0, tree_in_flat=0, rsp_valid=0, rsp_data=0, err_underflow=0
  - rr_ptr=0, tag FIFO empty (rd/wr pointers and count 0), all credit counters 0
  - req_ready is combinational and is 0 while rst is high.
- Eligibility: r is eligible if req_valid[r] && cnt[r] < MAX_OUT.
- Grant:
  - Scan eligible requesters from rr_ptr upward, modulo R; the first hit wins.
  - Nothing is granted if the tag FIFO is full. A pop in the same cycle does NOT free a slot.
- req_ready: one-hot at the winner, or all zeros. A handshake is req_valid[r] && req_ready[r].
- Accept cycle:
  - Next edge: tree_in_flat <= req_data slice of the winner; tree_valid_in <= 1.
  - Push the winner ID, width clog2(R), into the tag FIFO.
  - cnt[winner]++.
  - rr_ptr <= (winner+1) mod R.
- No accept: tree_valid_in <= 0; tree_in_flat holds its value; rr_ptr holds.
- Issue latency: 1 cycle from handshake to tree_valid_in. Sustained rate is 1 vector per cycle.
- Return on tree_valid_out:
  - Pop the head ID. Next edge: rsp_valid <= one-hot(ID), rsp_data <= tree_sum, cnt[ID]--.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
  - Requesters cannot backpressure results.
- Return ordering: results return in issue order. The tree is in-order, so the FIFO order matches.
- Simultaneous push and pop: both take effect and the count is unchanged.
- Same requester on push and pop in one cycle: cnt[r] is unchanged (net 0).
- Underflow: tree_valid_out with FIFO empty sets err_underflow. No pop, no rsp_valid, no counter change. Cleared only by rst.
- Counter width: clog2(MAX_OUT+1). A counter can never exceed MAX_OUT or drop below 0. An assertion in the bench checks this.
- Reset mid-operation: all state clears at once. In-flight tree results arriving after reset release hit an empty FIFO and set err_underflow. The integration owner resets the tree together with this block.
- The block contains no FP arithmetic; data passes through bit-exact.

Decomposition:
- Shared package fp16_pkg:
  - DW and N constants
  - clog2 function
  - R-bit round-robin helper constants
- Natural sub-module: tag_fifo (sync FIFO; W=clog2(R); depth TAG_DEPTH; push/pop/full/empty/count). Unit-tested on its own.
- Arbitration and credit counters stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-cycle, all req_valid=0.
  - Response: all outputs 0 immediately (async); busy=0; no tree_valid_in for 20 cycles.
- Single request:
  - Stimulus: r=2, vector of 128 × 0x3C00 (1.0); tree model with latency 7 returning 0x5800 (128.0).
  - Response: tree_valid_in 1 cycle after the handshake; rsp_valid=4'b0100 with rsp_data=0x5800 at the cycle after tree_valid_out; cnt[2] back to 0.
- Round-robin fairness:
  - Stimulus: all 4 requesters held valid with MAX_OUT large.
  - Response: grant order 0,1,2,3,0,1,…; each rsp_valid one-hot matches issue order; 1 issue per cycle.
- Credit limit:
  - Stimulus: requester 0 alone, MAX_OUT=4, tree latency 10.
  - Response: exactly 4 accepts, then req_ready[0]=0 until the first rsp_valid[0]; then 1 more accept.
- FIFO full:
  - Stimulus: TAG_DEPTH=4, tree latency 8, MAX_OUT=8, 2 requesters.
  - Response: accepts stop after 4 outstanding; the simultaneous pop cycle does not accept; resumes next cycle; no lost or duplicated tags.
- Underflow:
  - Stimulus: pulse tree_valid_out with FIFO empty.
  - Response: err_underflow=1 (sticky), rsp_valid stays 0; rst clears it.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared constants and helpers for the FP16 reduction-tree front end.
package fp16_pkg;

  localparam int DW = 16;
  localparam int N  = 128;

  // Legal requester count range for the round-robin arbiter
  localparam int RR_MIN_REQ = 2;
  localparam int RR_MAX_REQ = 8;

  // Ceiling log2, never less than 1 so single-entry fields stay legal
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/fp16_tree_arbiter_tag_fifo.sv
// Synchronous FIFO holding requester IDs for vectors in flight through the tree.
module tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push_i,
  input  logic [W-1:0]                         din_i,
  input  logic                                 pop_i,
  output logic [W-1:0]                         dout_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [fp16_pkg::clog2(DEPTH+1)-1:0]  count_o
);
  import fp16_pkg::*;

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fp16_tree_arbiter.sv
// Round-robin front end sharing one pipelined FP16 adder tree between R requesters;
// requester IDs ride a tag FIFO alongside the tree so each result is steered home.
module fp16_tree_arbiter #(
  parameter int DW        = fp16_pkg::DW,
  parameter int N         = fp16_pkg::N,
  parameter int R         = 4,
  parameter int TAG_DEPTH = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      req_valid,
  output logic [R-1:0]      req_ready,
  input  logic [R*N*DW-1:0] req_data,
  output logic              tree_valid_in,
  output logic [N*DW-1:0]   tree_in_flat,
  input  logic              tree_valid_out,
  input  logic [DW-1:0]     tree_sum,
  output logic [R-1:0]      rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              busy,
  output logic              err_underflow
);
  import fp16_pkg::*;

  localparam int TW  = clog2(R);
  localparam int CW  = clog2(MAX_OUT + 1);
  localparam int FCW = clog2(TAG_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [TW-1:0] LAST_ID = TW'(R - 1);

  logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q [R];
  logic [CW-1:0]   cnt_d [R];
  logic            tree_valid_in_q, tree_valid_in_d;
  logic [N*DW-1:0] tree_in_q, tree_in_d;
  logic [R-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            err_q, err_d;

  logic [R-1:0]    elig;
  logic [TW-1:0]   cand;
  logic            grant_any;
  logic [TW-1:0]   grant_id;
  logic            fifo_full, fifo_empty, pop;
  logic [TW-1:0]   head_id;
  logic [FCW-1:0]  fifo_count;

  always_comb begin
    elig = '0;
    for (int r = 0; r < R; r++) elig[r] = req_valid[r] && (cnt_q[r] < CNT_MAX);
  end

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < R; k++) begin
      cand = TW'((int'(rr_ptr_q) + k) % R);
      if (!grant_any && elig[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (rst || fifo_full) grant_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  assign pop = tree_valid_out && !fifo_empty;

  tag_fifo #(
    .W     (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant_any),
    .din_i   (grant_id),
    .pop_i   (pop),
    .dout_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    tree_valid_in_d = grant_any;
    tree_in_d       = tree_in_q;
    rsp_valid_d     = '0;
    rsp_data_d      = rsp_data_q;
    err_d           = err_q;
    for (int r = 0; r < R; r++) cnt_d[r] = cnt_q[r];

    if (grant_any) begin
      for (int r = 0; r < R; r++) begin
        if (grant_id == TW'(r)) tree_in_d = req_data[r*N*DW +: N*DW];
      end
      rr_ptr_d        = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      cnt_d[grant_id] = cnt_d[grant_id] + 1'b1;
    end

    // Applied after the increment so a same-requester push/pop nets to zero
    if (pop) begin
      rsp_valid_d[head_id] = 1'b1;
      rsp_data_d           = tree_sum;
      cnt_d[head_id]       = cnt_d[head_id] - 1'b1;
    end

    if (tree_valid_out && fifo_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      tree_valid_in_q <= 1'b0;
      tree_in_q       <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      err_q           <= 1'b0;
      for (int r = 0; r < R; r++) cnt_q[r] <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      tree_valid_in_q <= tree_valid_in_d;
      tree_in_q       <= tree_in_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      err_q           <= err_d;
      for (int r = 0; r < R; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign tree_valid_in = tree_valid_in_q;
  assign tree_in_flat  = tree_in_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign err_underflow = err_q;
  assign busy          = (fifo_count != '0) || tree_valid_in_q;

endmodule
